// File: rtl/nn_mac_neuron.sv
// Streaming multiply-accumulate neuron: LANES signed products per beat, N_IN/LANES beats per vector,
// bias on the first beat, then shift + saturate. Optional ReLU on the output: define NN_MAC_RELU_EN.
module nn_mac_neuron #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int N_IN   = 16,
  parameter int ACC_W  = 24,
  parameter int BIAS_W = 16,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 16,
  localparam int N_BEATS = N_IN / LANES,
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   weights,
  input  logic [LANES*DATA_W-1:0]   inputs,
  input  logic [BIAS_W-1:0]         bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat,
  output logic [BEAT_W-1:0]         beat_idx
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  state_t                  state;
  logic                    fire;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        sat_data;
  logic [OUT_W-1:0]        res_data;
  logic                    res_sat;

  assign in_ready = (state == ST_ACC);
  assign fire     = in_valid && in_ready;

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++)
      lane_sum = lane_sum + ACC_W'($signed(weights[k*DATA_W +: DATA_W]) *
                                   $signed(inputs[k*DATA_W +: DATA_W]));
  end

  assign bias_ext = ACC_W'($signed(bias));
  assign acc_next = ((beat_idx == '0) ? bias_ext : acc) + lane_sum;
  assign shifted  = acc_next >>> SHIFT;

  // Value fits when every bit from the output sign bit upward matches the accumulator sign.
  if (OUT_W < ACC_W) begin : g_sat
    always_comb begin
      res_sat = (shifted[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){shifted[ACC_W-1]}});
      if (!res_sat)
        sat_data = shifted[OUT_W-1:0];
      else if (shifted[ACC_W-1])
        sat_data = {1'b1, {(OUT_W-1){1'b0}}};
      else
        sat_data = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end else begin : g_wide
    assign res_sat  = 1'b0;
    assign sat_data = OUT_W'(shifted);
  end

`ifdef NN_MAC_RELU_EN
  assign res_data = sat_data[OUT_W-1] ? '0 : sat_data;
`else
  assign res_data = sat_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ACC;
      acc       <= '0;
      beat_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (fire) begin
            acc <= acc_next;
            if (beat_idx == LAST_BEAT) begin
              beat_idx  <= '0;
              out_data  <= res_data;
              out_sat   <= res_sat;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              beat_idx <= beat_idx + BEAT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mac_neuron.sv
// Directed bench for nn_mac_neuron: default build plus a SHIFT=4 instance sharing the same stimulus.
module tb_nn_mac_neuron;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] weights;
  logic [31:0] inputs;
  logic [15:0] bias;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_sat;
  logic [15:0] out_data;
  logic [1:0]  beat_idx;
  logic        in_ready4, out_valid4, out_sat4;
  logic [15:0] out_data4;
  logic [1:0]  beat_idx4;

  int n_checks = 0;
  int n_fail   = 0;
  int w[16];
  int x[16];

  nn_mac_neuron dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .weights(weights), .inputs(inputs), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .beat_idx(beat_idx)
  );

  nn_mac_neuron #(.SHIFT(4)) dut_s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .weights(weights), .inputs(inputs), .bias(bias),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_sat(out_sat4), .beat_idx(beat_idx4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int wv, input int x0, input int xinc);
    for (int i = 0; i < 16; i++) begin
      w[i] = wv;
      x[i] = x0 + xinc * i;
    end
  endtask

  task automatic send_beat(input int b);
    bit done;
    for (int k = 0; k < 4; k++) begin
      weights[k*8 +: 8] = 8'(w[b*4+k]);
      inputs[k*8 +: 8]  = 8'(x[b*4+k]);
    end
    in_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    if (!done) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int b, input bit gap);
    bias = 16'(b);
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) step();
      send_beat(i);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_beat_idx", int'(beat_idx), 0);
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int held;
    reset = 1'b1; in_valid = 1'b0; weights = '0; inputs = '0; bias = '0; out_ready = 1'b1;
    step(); step();
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_sat", int'(out_sat), 0);
    check("reset_beat_idx", int'(beat_idx), 0);
    reset = 1'b0;
    step();
    check("reset_in_ready", int'(in_ready), 1);

    // basic: 1..16 with unit weights
    fill(1, 1, 1);
    send_vec(0, 1'b0);
    check("basic_valid", int'(out_valid), 1);
    check("basic_in_ready_low", int'(in_ready), 0);
    check("basic_data", int'($signed(out_data)), 136);
    check("basic_sat", int'(out_sat), 0);
    step();
    check("basic_valid_clear", int'(out_valid), 0);
    check("basic_in_ready_back", int'(in_ready), 1);
    check("basic_data_hold", int'($signed(out_data)), 136);
    check("basic_beat_idx", int'(beat_idx), 0);

    // positive saturation
    fill(127, 127, 0);
    send_vec(100, 1'b0);
    check("possat_data", int'($signed(out_data)), 32767);
    check("possat_sat", int'(out_sat), 1);
    step();

    // negative saturation
    fill(-128, 127, 0);
    send_vec(0, 1'b0);
`ifdef NN_MAC_RELU_EN
    check("negsat_data", int'($signed(out_data)), 0);
`else
    check("negsat_data", int'($signed(out_data)), -32768);
`endif
    check("negsat_sat", int'(out_sat), 1);
    step();

    // backpressure with gaps between beats, then beats offered during HOLD
    out_ready = 1'b0;
    fill(1, 1, 1);
    send_vec(7, 1'b1);
    check("bp_valid", int'(out_valid), 1);
    check("bp_data", int'($signed(out_data)), 143);
    fill(2, 3, 0);
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 4; k++) begin
        weights[k*8 +: 8] = 8'(w[k]);
        inputs[k*8 +: 8]  = 8'(x[k]);
      end
      in_valid = 1'b1;
      step();
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_in_ready", int'(in_ready), 0);
      check("bp_hold_data", int'($signed(out_data)), 143);
      check("bp_hold_beat_idx", int'(beat_idx), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_valid", int'(out_valid), 0);
    send_vec(-10, 1'b0);
    check("bp_second_data", int'($signed(out_data)), 86);
    check("bp_second_sat", int'(out_sat), 0);
    step();

    // reset while a result is held
    out_ready = 1'b0;
    fill(1, 1, 0);
    send_vec(3, 1'b0);
    check("hold_rst_pre_valid", int'(out_valid), 1);
    do_reset();
    out_ready = 1'b1;

    // reset mid-vector
    fill(1, 1, 0);
    bias = 16'd100;
    send_beat(0);
    send_beat(1);
    check("mid_beat_idx", int'(beat_idx), 2);
    do_reset();
    held = 0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) held++;
      step();
    end
    check("mid_no_spurious_valid", held, 0);
    send_vec(5, 1'b0);
    check("mid_data", int'($signed(out_data)), 21);
    step();

    // SHIFT=4 instance
    fill(1, 1, 1);
    send_vec(-8, 1'b0);
    check("s4_pos_valid", int'(out_valid4), 1);
    check("s4_pos_data", int'($signed(out_data4)), 8);
    step();
    send_vec(-200, 1'b0);
    check("s4_neg_data", int'($signed(out_data4)), -4);
    check("s4_neg_sat", int'(out_sat4), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
